// File: rtl/cal_period_meas.sv
// Calibration half-period meter: counts clk_dds cycles between cal_in edges,
// sums NUM_HALF half-periods and compares the total with the expected divider setting.
module cal_period_meas #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_HALF = 8,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic             clk_dds,
    input  logic             rst_n,
    input  logic             meas_start,
    input  logic             cal_in,
    input  logic [5:0]       exp_para,
    output logic             busy,
    output logic             meas_done,
    output logic [CNT_W-1:0] meas_sum,
    output logic [CNT_W-1:0] hp_last,
    output logic             match,
    output logic             timeout
);

    localparam int unsigned HC_W  = 8;
    localparam int unsigned EXP_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sync_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   sum_acc_q, sum_acc_d;
    logic [HC_W-1:0]    half_cnt_q, half_cnt_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   meas_sum_q, meas_sum_d;
    logic [CNT_W-1:0]   hp_last_q, hp_last_d;
    logic               match_q, match_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               edge_pulse;
    logic [CNT_W-1:0]   sum_edge;
    logic [CNT_W-1:0]   exp_total;
    logic [HC_W-1:0]    half_next;

    // Double-flop synchroniser plus one delay stage for any-edge detection
    always_ff @(posedge clk_dds or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], cal_in};
    end

    assign edge_pulse = sync_q[1] ^ sync_q[2];

    always_ff @(posedge clk_dds or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sum_acc_q  <= '0;
            half_cnt_q <= '0;
            exp_q      <= '0;
            meas_sum_q <= '0;
            hp_last_q  <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_acc_q  <= sum_acc_d;
            half_cnt_q <= half_cnt_d;
            exp_q      <= exp_d;
            meas_sum_q <= meas_sum_d;
            hp_last_q  <= hp_last_d;
            match_q    <= match_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_acc_d  = sum_acc_q;
        half_cnt_d = half_cnt_q;
        exp_d      = exp_q;
        meas_sum_d = meas_sum_q;
        hp_last_d  = hp_last_q;
        match_d    = match_q;
        done_d     = 1'b0;
        sum_edge   = sum_acc_q + cnt_q;
        exp_total  = CNT_W'(exp_q) * CNT_W'(NUM_HALF);
        half_next  = half_cnt_q + HC_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                sum_acc_d  = '0;
                half_cnt_d = '0;
                if (meas_start) begin
                    exp_d   = exp_para;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // First edge only aligns the measurement; the partial period is dropped
                if (edge_pulse) begin
                    cnt_d      = CNT_W'(1);
                    sum_acc_d  = '0;
                    half_cnt_d = '0;
                    state_d    = ST_MEAS;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (edge_pulse) begin
                    sum_acc_d  = sum_edge;
                    hp_last_d  = cnt_q;
                    half_cnt_d = half_next;
                    cnt_d      = CNT_W'(1);
                    // Closing edge doubles as the opening edge of the next result
                    if (half_next == HC_W'(NUM_HALF)) begin
                        meas_sum_d = sum_edge;
                        match_d    = (sum_edge == exp_total);
                        done_d     = 1'b1;
                        sum_acc_d  = '0;
                        half_cnt_d = '0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping the enable overrides everything, including a closing edge
        if (!meas_start) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            sum_acc_d  = '0;
            half_cnt_d = '0;
            exp_d      = exp_q;
            meas_sum_d = meas_sum_q;
            hp_last_d  = hp_last_q;
            match_d    = match_q;
            done_d     = 1'b0;
        end

        busy_d    = (state_d == ST_ARM) || (state_d == ST_MEAS);
        timeout_d = (state_d == ST_FAULT);
    end

    assign busy      = busy_q;
    assign meas_done = done_q;
    assign meas_sum  = meas_sum_q;
    assign hp_last   = hp_last_q;
    assign match     = match_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cal_period_meas.sv
// Directed bench for cal_period_meas: steady periods, enable drop, async reset, timeout.
module tb_cal_period_meas;

    logic        clk_dds;
    logic        rst_n;
    logic        meas_start;
    logic        cal_in;
    logic [5:0]  exp_para;
    logic        busy;
    logic        meas_done;
    logic [15:0] meas_sum;
    logic [15:0] hp_last;
    logic        match;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int hp;
    int gen_cnt;
    bit gen_en;
    int w;
    int ndone;

    cal_period_meas #(
        .CNT_W   (16),
        .NUM_HALF(8),
        .TIMEOUT (4096)
    ) dut (
        .clk_dds   (clk_dds),
        .rst_n     (rst_n),
        .meas_start(meas_start),
        .cal_in    (cal_in),
        .exp_para  (exp_para),
        .busy      (busy),
        .meas_done (meas_done),
        .meas_sum  (meas_sum),
        .hp_last   (hp_last),
        .match     (match),
        .timeout   (timeout)
    );

    initial begin
        clk_dds = 1'b0;
        forever #5 clk_dds = ~clk_dds;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the rising edge; cal_in toggles every hp ticks
    task automatic tick();
        @(posedge clk_dds);
        #1;
        if (gen_en) begin
            gen_cnt++;
            if (gen_cnt >= hp) begin
                cal_in  = ~cal_in;
                gen_cnt = 0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (meas_done !== 1'b1 && waited < budget);
        chk(tag, 32'(meas_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; meas_start = 1'b0; cal_in = 1'b0; exp_para = 6'd0;
        hp = 5; gen_cnt = 0; gen_en = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(meas_done), 32'd0);
        chk("rst_sum", 32'(meas_sum), 32'd0);
        chk("rst_hp", 32'(hp_last), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Half-period 5, expected 5
        exp_para = 6'd5; hp = 5; gen_cnt = 0; gen_en = 1'b1; meas_start = 1'b1;
        wait_done("t1_first_done", 200, w);
        chk("t1_latency", 32'(w), 32'd48);
        chk("t1_sum", 32'(meas_sum), 32'd40);
        chk("t1_hp", 32'(hp_last), 32'd5);
        chk("t1_match", 32'(match), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_next_done", 200, w);
        chk("t1_spacing", 32'(w), 32'd40);
        chk("t1_sum2", 32'(meas_sum), 32'd40);

        // Drop enable three half-periods into the next result
        ndone = 0;
        repeat (17) begin tick(); ndone += 32'(meas_done); end
        meas_start = 1'b0;
        tick();
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (60) begin tick(); ndone += 32'(meas_done); end
        chk("t4_no_done", 32'(ndone), 32'd0);
        chk("t4_sum", 32'(meas_sum), 32'd40);
        chk("t4_hp", 32'(hp_last), 32'd5);
        chk("t4_match", 32'(match), 32'd1);

        // Drop enable in the same cycle as the closing edge pulse
        meas_start = 1'b1;
        wait_done("t6_first_done", 200, w);
        chk("t6_sum", 32'(meas_sum), 32'd40);
        ndone = 0;
        repeat (39) begin tick(); ndone += 32'(meas_done); end
        meas_start = 1'b0;
        tick();
        chk("t6_done_blocked", 32'(meas_done), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_early_done", 32'(ndone), 32'd0);
        chk("t6_sum_hold", 32'(meas_sum), 32'd40);
        chk("t6_match_hold", 32'(match), 32'd1);

        // Half-period 6 against expected 5; a live exp_para change is ignored
        hp = 6; meas_start = 1'b1;
        wait_done("t2_first_done", 200, w);
        chk("t2_sum", 32'(meas_sum), 32'd48);
        chk("t2_hp", 32'(hp_last), 32'd6);
        chk("t2_match", 32'(match), 32'd0);
        exp_para = 6'd6;
        wait_done("t2_next_done", 200, w);
        chk("t2_spacing", 32'(w), 32'd48);
        chk("t2_sum2", 32'(meas_sum), 32'd48);
        chk("t2_match_latched", 32'(match), 32'd0);

        // Asynchronous reset mid-measurement
        tick(); tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(meas_done), 32'd0);
        chk("t5_sum", 32'(meas_sum), 32'd0);
        chk("t5_hp", 32'(hp_last), 32'd0);
        chk("t5_match", 32'(match), 32'd0);
        chk("t5_timeout", 32'(timeout), 32'd0);
        gen_en = 1'b0; cal_in = 1'b0; exp_para = 6'd5; hp = 5;
        tick();
        tick();
        rst_n = 1'b1; gen_cnt = 0; gen_en = 1'b1;
        wait_done("t5_done_after_rst", 200, w);
        chk("t5_rearm_latency", 32'(w), 32'd48);
        chk("t5_sum_after", 32'(meas_sum), 32'd40);
        chk("t5_match_after", 32'(match), 32'd1);

        // cal_in stuck low: timeout fault
        meas_start = 1'b0; gen_en = 1'b0; cal_in = 1'b0;
        repeat (5) tick();
        meas_start = 1'b1;
        ndone = 0;
        repeat (4096) begin tick(); ndone += 32'(meas_done); end
        chk("t3_no_early_fault", 32'(timeout), 32'd0);
        chk("t3_busy_arm", 32'(busy), 32'd1);
        repeat (2) begin tick(); ndone += 32'(meas_done); end
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_busy_fault", 32'(busy), 32'd0);
        chk("t3_no_done", 32'(ndone), 32'd0);
        meas_start = 1'b0;
        tick();
        chk("t3_timeout_clr", 32'(timeout), 32'd0);
        chk("t3_busy_idle", 32'(busy), 32'd0);
        chk("t3_sum_hold", 32'(meas_sum), 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
